fpu_dp_add_seq: RTL

FPU_DP_ADD_SEQ -- requirements
Module: fpu_dp_add_seq

---
 rtl/fpu_dp_add_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/fpu_dp_add_seq.sv
// rtl/fpu_dp_add_seq.sv - request/response sequencer around a multi-cycle double-precision adder core
// Optional flag generation is enabled by defining FPU_DP_ADD_SEQ_FLAGS_EN; rsp_flags = {NV,DZ,OF,UF,NX}.
module fpu_dp_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_op,
  input  logic [4:0]  req_tag,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [63:0] add_din1,
  output logic [63:0] add_din2,
  output logic        add_dval,
  input  logic [63:0] add_result,
  input  logic        add_rdy,
  output logic        rsp_val,
  input  logic        rsp_rdy,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_tag,
  output logic [4:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, DRAIN} state_t;

  localparam logic [63:0] TIMEOUT_NAN = 64'h7FF8000000000000;
  localparam logic [11:0] WAIT_LIMIT  = 12'hFFF;

  state_t      state;
  logic [11:0] wait_cnt;
  logic        accept;
  logic [63:0] eff_b;

  assign accept = (state == IDLE) && req_rdy && req_val;
  // Subtraction is an addition with the second operand's sign flipped.
  assign eff_b  = {req_b[63] ^ req_op, req_b[62:0]};
  assign busy   = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_rdy  <= 1'b0;
      add_dval <= 1'b0;
      add_din1 <= 64'd0;
      add_din2 <= 64'd0;
      rsp_val  <= 1'b0;
      rsp_data <= 64'd0;
      rsp_tag  <= 5'd0;
      rsp_err  <= 1'b0;
      wait_cnt <= 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_rdy  <= 1'b0;
            add_din1 <= req_a;
            add_din2 <= eff_b;
            rsp_tag  <= req_tag;
            rsp_err  <= 1'b0;
            add_dval <= 1'b1;
            state    <= ISSUE;
          end else begin
            req_rdy <= 1'b1;
          end
        end
        ISSUE: begin
          add_dval <= 1'b0;
          wait_cnt <= 12'd0;
          state    <= WAIT;
        end
        WAIT: begin
          if (add_rdy) begin
            rsp_data <= add_result;
            rsp_val  <= 1'b1;
            state    <= RESP;
          end else if (wait_cnt == WAIT_LIMIT) begin
            rsp_data <= TIMEOUT_NAN;
            rsp_err  <= 1'b1;
            rsp_val  <= 1'b1;
            state    <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 12'd1;
          end
        end
        RESP: begin
          if (rsp_rdy) begin
            rsp_val <= 1'b0;
            // A timed-out core still owes us a done pulse; absorb it before reuse.
            if (rsp_err) begin
              state <= DRAIN;
            end else begin
              state   <= IDLE;
              req_rdy <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (add_rdy) begin
            rsp_err <= 1'b0;
            state   <= IDLE;
            req_rdy <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FPU_DP_ADD_SEQ_FLAGS_EN
  function automatic logic is_inf(input logic [62:0] x);
    return (&x[62:52]) && (x[51:0] == 52'd0);
  endfunction

  function automatic logic is_nan(input logic [62:0] x);
    return (&x[62:52]) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic is_snan(input logic [62:0] x);
    return is_nan(x) && !x[51];
  endfunction

  logic       nv_acc;
  logic       special_acc;
  logic       nv_q;
  logic       special_q;
  logic [4:0] flags_q;

  assign nv_acc = is_snan(req_a[62:0]) || is_snan(eff_b[62:0]) ||
                  (is_inf(req_a[62:0]) && is_inf(eff_b[62:0]) && (req_a[63] != eff_b[63]));
  // Overflow only counts when the infinity was produced, not propagated.
  assign special_acc = is_inf(req_a[62:0]) || is_nan(req_a[62:0]) ||
                       is_inf(eff_b[62:0]) || is_nan(eff_b[62:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nv_q      <= 1'b0;
      special_q <= 1'b0;
      flags_q   <= 5'd0;
    end else if (accept) begin
      nv_q      <= nv_acc;
      special_q <= special_acc;
      flags_q   <= 5'd0;
    end else if (state == WAIT) begin
      if (add_rdy) begin
        flags_q <= {nv_q, 1'b0, is_inf(add_result[62:0]) && !special_q, 2'b00};
      end else if (wait_cnt == WAIT_LIMIT) begin
        flags_q <= {nv_q, 4'b0000};
      end
    end
  end

  assign rsp_flags = flags_q;
`else
  assign rsp_flags = 5'b00000;
`endif

endmodule
